// File: rtl/signature_checker.sv
// rtl/signature_checker.sv - captures the final accumulator signature once per run and offers it to a logger
//
// Ports:
//   clk            : single clock, rising edge
//   clear_n        : asynchronous active-low reset, clears every register
//   acc_in         : accumulator output (signature under test)
//   full_bar       : counter-full detector, 0 = counter full / accumulator frozen
//   expected       : golden signature, stable during a run
//   sig_ready      : logger accepts the presented signature
//   sig_out        : captured signature
//   sig_valid      : sig_out valid and awaiting acceptance
//   match          : captured signature equalled expected at capture
//   overrun        : sticky, a run completed while the previous signature was unaccepted
//   run_count      : saturating count of captures
//   mismatch_count : saturating count of captures with match = 0
//
// Build option: SIG_CHECK_COMPARE_EN enables the comparator and mismatch counter;
// when undefined, match and mismatch_count are tied to 0 and expected is ignored.
module signature_checker #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic [WIDTH-1:0] acc_in,
    input  logic             full_bar,
    input  logic [WIDTH-1:0] expected,
    input  logic             sig_ready,
    output logic [WIDTH-1:0] sig_out,
    output logic             sig_valid,
    output logic             match,
    output logic             overrun,
    output logic [CNT_W-1:0] run_count,
    output logic [CNT_W-1:0] mismatch_count
);

    typedef enum logic [1:0] {
        WAIT_ARM = 2'd0,
        ARMED    = 2'd1,
        PRESENT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state, state_nxt;
    logic   full_q;
    logic   capture;
    logic   accept;
    logic   new_fall;

    // State register; full_q remembers last cycle's full_bar so a fresh
    // counter-full edge can be recognised while a signature is still pending.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state  <= WAIT_ARM;
            full_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            full_q <= full_bar;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            WAIT_ARM: if (full_bar) state_nxt = ARMED;
            ARMED:    if (!full_bar) state_nxt = PRESENT;
            PRESENT: begin
                // A new run finishing on the accepting edge is never captured,
                // so full_bar = 0 here always lands in WAIT_ARM.
                if (accept) state_nxt = full_bar ? ARMED : WAIT_ARM;
            end
            default:  state_nxt = WAIT_ARM;
        endcase
    end

    // Output / control decode
    always_comb begin
        sig_valid = (state == PRESENT);
        accept    = (state == PRESENT) && sig_ready;
        capture   = (state == ARMED) && !full_bar;
        new_fall  = full_q && !full_bar;
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            sig_out   <= '0;
            run_count <= '0;
            overrun   <= 1'b0;
        end else begin
            if (capture) begin
                sig_out <= acc_in;
                if (run_count != CNT_MAX) run_count <= run_count + CNT_ONE;
            end
            if ((state == PRESENT) && new_fall) overrun <= 1'b1;
        end
    end

`ifdef SIG_CHECK_COMPARE_EN
    logic is_match;

    assign is_match = (acc_in == expected);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            match          <= 1'b0;
            mismatch_count <= '0;
        end else if (capture) begin
            match <= is_match;
            if (!is_match && (mismatch_count != CNT_MAX))
                mismatch_count <= mismatch_count + CNT_ONE;
        end
    end
`else
    logic unused_expected;

    assign unused_expected = ^expected;
    assign match           = 1'b0;
    assign mismatch_count  = '0;
`endif

endmodule

// File: doc/signature_checker.md
# signature_checker

Downstream consumer of the signature accumulator: watches the counter-full indicator and captures the final 16-bit accumulated signature once per test run. Offers the signature to a logger over a valid/ready handshake. Compares it against an expected value and keeps saturating run and mismatch counts. Sits between the accumulator/rotator loop and the result logger.

## Interface
- `WIDTH`, 16, signature width in bits
- `CNT_W`, 8, width of the run and mismatch counters
- `clk` in 1: single clock; all state changes on the rising edge
- `clear_n` in 1: reset, asynchronous, active-low; asserts immediately, clears every register
- `acc_in` in WIDTH: accumulator output (signature under test)
- `full_bar` in 1: counter-full detector; 0 = stimulus counter full and accumulator frozen
- `expected` in WIDTH: golden signature, stable while a run is in progress
- `sig_ready` in 1: logger accepts the signature
- `sig_out` out WIDTH: captured signature
- `sig_valid` out 1: `sig_out` is valid and awaiting acceptance
- `match` out 1: captured signature equals `expected` sampled at capture
- `overrun` out 1: sticky; a run completed while the previous signature was unaccepted
- `run_count` out CNT_W: captures performed, saturating
- `mismatch_count` out CNT_W: captures with `match`=0, saturating

## Operation
- Reset values: `sig_out`=0, `sig_valid`=0, `match`=0, `overrun`=0, `run_count`=0, `mismatch_count`=0, state WAIT_ARM, `full_q`=0.
- `full_q` is a register holding the previous-cycle `full_bar`.
- WAIT_ARM: on an edge with `full_bar`=1, go to ARMED. A full counter seen before any counting is never captured.
- ARMED: on an edge with `full_bar`=0, perform a capture and go to PRESENT. A capture does all of the following:
  - `sig_out`<=`acc_in`
  - `match`<=(`acc_in`==`expected`)
  - `run_count`+=1
  - `mismatch_count`+=1 if `acc_in`!=`expected`
  - `sig_valid`<=1
- PRESENT: `sig_valid`=1; `sig_out` and `match` are held.
  - On an edge with `sig_valid`&&`sig_ready`, clear `sig_valid`. Go to ARMED if `full_bar`=1, else WAIT_ARM.
  - On an edge with `full_q`=1 and `full_bar`=0 and no acceptance, set `overrun`. The new signature is discarded and the old one held.
- Acceptance and a new full-edge on the same edge: accept the old signature, set `overrun`, and go to WAIT_ARM. The new run is not captured.
- Counters saturate at 2^CNT_W−1 and never wrap.
- `overrun` clears only on reset.
- Reset mid-run or mid-handshake: everything returns to reset values on `clear_n` assertion, with no waiting for a clock edge.

## Timing
- Capture latency: signature visible on `sig_out` with `sig_valid`=1 one cycle after the first edge that samples `full_bar`=0 in ARMED.
- `acc_in` is sampled on that edge. The accumulator is frozen then, so the value is final.
- `sig_valid` stays high until the accepting edge and drops on the cycle after it. Minimum valid pulse is one cycle when `sig_ready` is already high.
- `sig_out` and `match` do not change while `sig_valid`=1.
- `clear_n` deassertion is synchronised externally. The block needs one edge with `clear_n`=1 before sampling `full_bar`.

## Configuration
- `SIG_CHECK_COMPARE_EN` defined:
  - `match` and `mismatch_count` behave as above.
  - `expected` is used.
- `SIG_CHECK_COMPARE_EN` not defined:
  - The comparator and mismatch counter are removed.
  - `match` and `mismatch_count` are tied to 0.
  - `expected` is ignored.
  - Capture, handshake, `run_count` and `overrun` are unchanged.

## Test plan
- **Basic capture:** reset, `full_bar`=1 for 10 cycles, `acc_in`=0x1234, `expected`=0x1234, `sig_ready`=1, then `full_bar`=0. Required: `sig_valid`=1 for exactly one cycle, `sig_out`=0x1234, `match`=1, `run_count`=1, `mismatch_count`=0.
- **Mismatch plus held output:** `acc_in`=0xBEEF, `expected`=0x1234, `sig_ready`=0 for 5 cycles after capture. Required: `sig_valid` high for all 5 cycles, `sig_out`=0xBEEF held while `acc_in` changes, `match`=0, `mismatch_count`=1.
- **Overrun:** `sig_ready`=0, `full_bar` toggles 1→0 twice. Required: `overrun`=1 after the second falling edge, `sig_out` still holds the first signature, `run_count`=1.
- **Never armed:** `full_bar`=0 from reset onward. Required: no capture, `sig_valid`=0, `run_count`=0.
- **Async reset mid-handshake:** pulse `clear_n` low for 0.3 cycle while `sig_valid`=1. Required: all outputs 0 immediately, before the next edge.
- **Saturation:** 260 complete runs with mismatching signatures. Required: `run_count`=`mismatch_count`=255.
